// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder built from one full_adder cell and a carry flop
// Define SERIAL_ADDER_OVERFLOW_EN to add the registered signed-overflow output overflow_o.

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic carry_i,
  output logic sum_o,
  output logic carry_o
);
  assign sum_o   = a_i ^ b_i ^ carry_i;
  assign carry_o = (a_i & b_i) | (carry_i & (a_i ^ b_i));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
`ifdef SERIAL_ADDER_OVERFLOW_EN
  output logic             carry_o,
  output logic             overflow_o
`else
  output logic             carry_o
`endif
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Holds the WIDTH-1 sum bits produced so far; the last bit goes straight to sum_o.
  logic [WIDTH-2:0] res_sr;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_carry;
  logic             last_bit;

  full_adder u_fa (
    .a_i     (a_sr[0]),
    .b_i     (b_sr[0]),
    .carry_i (carry_q),
    .sum_o   (fa_sum),
    .carry_o (fa_carry)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign busy_o   = (state == SHIFT);
  assign done_o   = (state == DONE);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      carry_q    <= 1'b0;
      cnt        <= '0;
      sum_o      <= '0;
      carry_o    <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      overflow_o <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            a_sr    <= a_i;
            b_sr    <= b_i;
            carry_q <= carry_i;
            cnt     <= '0;
          end
        end
        SHIFT: begin
          res_sr  <= (WIDTH-1)'({fa_sum, res_sr} >> 1);
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          carry_q <= fa_carry;
          cnt     <= cnt + CW'(1);
          if (last_bit) begin
            sum_o      <= {fa_sum, res_sr};
            carry_o    <= fa_carry;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            // carry_q is the carry into the MSB on the final bit.
            overflow_o <= carry_q ^ fa_carry;
`endif
          end
        end
        default: ;
      endcase
    end
  end
endmodule
